// File: rtl/mig_pkg.sv
// Shared MIG definitions: FSM state encoding and default 200 MHz timing values
// used by the calibration monitor and the reset generator.
package mig_pkg;

  localparam int unsigned MIG_STATE_WIDTH   = 3;
  localparam int unsigned MIG_COUNTER_WIDTH = 24;
  localparam int unsigned MIG_RETRY_HOLD    = 40000;    // 200 us at 200 MHz
  localparam int unsigned MIG_CALIB_TIMEOUT = 2000000;  // 10 ms at 200 MHz
  localparam int unsigned MIG_STABLE_CYCLES = 64;
  localparam int unsigned MIG_MAX_RETRIES   = 3;
  localparam int unsigned MIG_RETRY_WIDTH   = 2;

  typedef enum logic [MIG_STATE_WIDTH-1:0] {
    ST_IDLE       = 3'd0,
    ST_HOLD       = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_STABLE     = 3'd3,
    ST_READY      = 3'd4,
    ST_FAULT      = 3'd5
  } mig_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
// Ports: clk, rst_n, d (async input), q (synchronized, 2-cycle latency).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mig_calib_monitor.sv
// Sequences the DDR MIG from reset release through calibration to a qualified
// ready indication, retrying by re-pulsing MIG reset and latching a sticky fault
// once the retry budget is spent.
// Ports:
//   i_Clock, i_Reset_N (async active-low)  clock and reset
//   i_Enable          sequence enable; low aborts to IDLE
//   i_Calib_Complete  MIG init_calib_complete (asynchronous)
//   o_Mig_Reset       MIG sys_rst_n drive (1 = released)
//   o_Ready           calibration qualified
//   o_Fault           retries exhausted (sticky until enable low / reset)
//   o_Retry_Count     retries consumed
//   o_State           current FSM state encoding
//   o_Calib_Latency   only with CALIB_MONITOR_LATENCY_EN: timeout count at READY entry
module mig_calib_monitor
  import mig_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = MIG_COUNTER_WIDTH,
  parameter int unsigned RETRY_HOLD    = MIG_RETRY_HOLD,
  parameter int unsigned CALIB_TIMEOUT = MIG_CALIB_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = MIG_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = MIG_MAX_RETRIES,
  parameter int unsigned RETRY_WIDTH   = MIG_RETRY_WIDTH
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_N,
  input  logic                       i_Enable,
  input  logic                       i_Calib_Complete,
  output logic                       o_Mig_Reset,
  output logic                       o_Ready,
  output logic                       o_Fault,
  output logic [RETRY_WIDTH-1:0]     o_Retry_Count,
  output logic [MIG_STATE_WIDTH-1:0] o_State
`ifdef CALIB_MONITOR_LATENCY_EN
  ,
  output logic [COUNTER_WIDTH-1:0]   o_Calib_Latency
`endif
);

  mig_state_e               state;
  logic                     calib_s;
  logic [COUNTER_WIDTH-1:0] hold_cnt;
  logic [COUNTER_WIDTH-1:0] tmo_cnt;
  logic [COUNTER_WIDTH-1:0] stable_cnt;

  logic tmo_hit_c;
  logic hold_done_c;
  logic stable_done_c;
  logic exhausted_c;
  logic retry_c;
  logic enter_hold_c;
  logic enter_ready_c;

  // Only the synchronized calibration flag is used by the FSM
  sync_2ff #(.WIDTH(1)) u_calib_sync (
    .clk   (i_Clock),
    .rst_n (i_Reset_N),
    .d     (i_Calib_Complete),
    .q     (calib_s)
  );

  assign tmo_hit_c     = (tmo_cnt == COUNTER_WIDTH'(CALIB_TIMEOUT - 1));
  assign hold_done_c   = (hold_cnt == COUNTER_WIDTH'(RETRY_HOLD - 1));
  assign stable_done_c = (stable_cnt == COUNTER_WIDTH'(STABLE_CYCLES - 1));
  assign exhausted_c   = (o_Retry_Count == RETRY_WIDTH'(MAX_RETRIES));

  // Retry trigger: timeout while calibrating (beats any calib progress) or loss in READY
  always_comb begin
    retry_c = 1'b0;
    case (state)
      ST_WAIT_CALIB, ST_STABLE: retry_c = tmo_hit_c;
      ST_READY:                 retry_c = !calib_s;
      default:                  retry_c = 1'b0;
    endcase
  end

  assign enter_hold_c  = (state == ST_IDLE) || (retry_c && !exhausted_c);
  assign enter_ready_c = (state == ST_STABLE) && !tmo_hit_c && calib_s && stable_done_c;

  assign o_State = state;

  // Sequencer FSM, counters and registered outputs
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      tmo_cnt       <= '0;
      stable_cnt    <= '0;
      o_Retry_Count <= '0;
      o_Mig_Reset   <= 1'b0;
      o_Ready       <= 1'b0;
      o_Fault       <= 1'b0;
    end else if (!i_Enable) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      tmo_cnt       <= '0;
      stable_cnt    <= '0;
      o_Retry_Count <= '0;
      o_Mig_Reset   <= 1'b0;
      o_Ready       <= 1'b0;
      o_Fault       <= 1'b0;
    end else if (retry_c) begin
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      stable_cnt  <= '0;
      o_Mig_Reset <= 1'b0;
      o_Ready     <= 1'b0;
      if (exhausted_c) begin
        state   <= ST_FAULT;
        o_Fault <= 1'b1;
      end else begin
        state         <= ST_HOLD;
        o_Retry_Count <= o_Retry_Count + RETRY_WIDTH'(1);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_HOLD;
          hold_cnt <= '0;
        end
        ST_HOLD: begin
          if (hold_done_c) begin
            state       <= ST_WAIT_CALIB;
            tmo_cnt     <= '0;
            o_Mig_Reset <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + COUNTER_WIDTH'(1);
          end
        end
        ST_WAIT_CALIB: begin
          tmo_cnt <= tmo_cnt + COUNTER_WIDTH'(1);
          if (calib_s) begin
            state      <= ST_STABLE;
            stable_cnt <= '0;
          end
        end
        ST_STABLE: begin
          if (!calib_s) begin
            state      <= ST_WAIT_CALIB;
            stable_cnt <= '0;
            tmo_cnt    <= tmo_cnt + COUNTER_WIDTH'(1);
          end else if (stable_done_c) begin
            state   <= ST_READY;
            o_Ready <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + COUNTER_WIDTH'(1);
            tmo_cnt    <= tmo_cnt + COUNTER_WIDTH'(1);
          end
        end
        ST_READY, ST_FAULT: begin
          state <= state;
        end
        default: begin
          state       <= ST_IDLE;
          o_Mig_Reset <= 1'b0;
          o_Ready     <= 1'b0;
          o_Fault     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CALIB_MONITOR_LATENCY_EN
  // Captures how long calibration took within the current release window
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      o_Calib_Latency <= '0;
    end else if (!i_Enable || enter_hold_c) begin
      o_Calib_Latency <= '0;
    end else if (enter_ready_c) begin
      o_Calib_Latency <= tmo_cnt;
    end
  end
`else
  // Latency capture not built; enter_ready_c only feeds the optional register
  logic unused_c;
  assign unused_c = enter_ready_c & enter_hold_c;
`endif

endmodule

// File: tb/tb_mig_calib_monitor.sv
// Scoreboard bench for mig_calib_monitor: a timeline model pushes every expected
// output change (edge number + values) and a negedge monitor pops and compares
// whenever the DUT outputs change.
`timescale 1ns/1ps
module tb_mig_calib_monitor;

  localparam int unsigned CW = 8;
  localparam int unsigned RH = 10;
  localparam int unsigned CT = 50;
  localparam int unsigned SC = 4;
  localparam int unsigned MR = 2;
  localparam int unsigned RW = 2;

  localparam int PH_OFF = 0;
  localparam int PH_LOW = 1;
  localparam int PH_REL = 2;
  localparam int PH_RDY = 3;
  localparam int PH_FLT = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          calib = 1'b0;
  logic          mig_rst;
  logic          rdy;
  logic          flt;
  logic [RW-1:0] rcnt;
  logic [2:0]    st;
`ifdef CALIB_MONITOR_LATENCY_EN
  logic [CW-1:0] lat;
`endif

  mig_calib_monitor #(
    .COUNTER_WIDTH (CW),
    .RETRY_HOLD    (RH),
    .CALIB_TIMEOUT (CT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR),
    .RETRY_WIDTH   (RW)
  ) dut (
    .i_Clock          (clk),
    .i_Reset_N        (rst_n),
    .i_Enable         (en),
    .i_Calib_Complete (calib),
    .o_Mig_Reset      (mig_rst),
    .o_Ready          (rdy),
    .o_Fault          (flt),
    .o_Retry_Count    (rcnt),
    .o_State          (st)
`ifdef CALIB_MONITOR_LATENCY_EN
    ,
    .o_Calib_Latency  (lat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  vec;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Timeline model: phase plus absolute edge times, run length of synced highs
  int          m_phase   = PH_OFF;
  int unsigned mt        = 0;
  int unsigned m_rel_at  = 0;
  int unsigned m_rel     = 0;
  int unsigned m_run     = 0;
  int unsigned m_retries = 0;
  int unsigned m_lat     = 0;
  logic        h1 = 1'b0, h2 = 1'b0;
  logic [7:0]  m_prev = 8'h00;

  task automatic run_edge(input logic e_in, input logic c_in);
    logic       s;
    logic       retry;
    logic [2:0] stv;
    logic [7:0] v;
    en    = e_in;
    calib = c_in;
    mt++;
    // calibration level the sequencer acts on is the one sampled two edges earlier
    s  = h2;
    h2 = h1;
    h1 = c_in;
    retry = 1'b0;
    if (!e_in) begin
      m_phase   = PH_OFF;
      m_retries = 0;
    end else begin
      case (m_phase)
        PH_OFF: begin m_phase = PH_LOW; m_rel_at = mt + RH; end
        PH_LOW: if (mt == m_rel_at) begin m_phase = PH_REL; m_rel = mt; m_run = 0; end
        PH_REL: begin
          if (mt == m_rel + CT) retry = 1'b1;
          else begin
            m_run = s ? m_run + 1 : 0;
            if (m_run == SC + 1) begin m_phase = PH_RDY; m_lat = mt - m_rel - 1; end
          end
        end
        PH_RDY: if (!s) retry = 1'b1;
        default: ;
      endcase
    end
    if (retry) begin
      if (m_retries == MR) m_phase = PH_FLT;
      else begin m_retries++; m_phase = PH_LOW; m_rel_at = mt + RH; end
    end
    case (m_phase)
      PH_OFF:  stv = 3'd0;
      PH_LOW:  stv = 3'd1;
      PH_REL:  stv = (m_run > 0) ? 3'd3 : 3'd2;
      PH_RDY:  stv = 3'd4;
      default: stv = 3'd5;
    endcase
    v = {(m_phase == PH_REL || m_phase == PH_RDY), (m_phase == PH_RDY),
         (m_phase == PH_FLT), 2'(m_retries), stv};
    if (v != m_prev) begin
      sbq.push_back('{cyc: mt, vec: v});
      m_prev = v;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int ph, input logic e_in, input logic c_in,
                            input int budget, input string name);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      run_edge(e_in, c_in);
      n++;
    end
    if (m_phase != ph) begin
      total++;
      bad++;
      $display("FAIL %s: bound expired after %0d edges, phase=%0d required=%0d", name, n, m_phase, ph);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, want);
    end
  endtask

  // Monitor: any change on the outputs must match the next scoreboard entry
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  mon_cur;
  logic [7:0]  mon_prev = 8'h00;
  exp_t        mon_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      mon_cur = {mig_rst, rdy, flt, rcnt, st};
      if (mon_cur !== mon_prev) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL out_change: unexpected at edge %0d got=%b", cyc, mon_cur);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.cyc != cyc || mon_e.vec !== mon_cur) begin
            bad++;
            $display("FAIL out_change: edge=%0d got=%b required edge=%0d vec=%b",
                     cyc, mon_cur, mon_e.cyc, mon_e.vec);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_mig", 32'(mig_rst), 32'd0);
    check("reset_ready", 32'(rdy), 32'd0);
    check("reset_fault", 32'(flt), 32'd0);
    check("reset_retry", 32'(rcnt), 32'd0);
    check("reset_state", 32'(st), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Nominal: calib rises 5 cycles after release
    run_edge(1'b1, 1'b0);
    wait_phase(PH_REL, 1'b1, 1'b0, 40, "nominal_release");
    repeat (5) run_edge(1'b1, 1'b0);
    wait_phase(PH_RDY, 1'b1, 1'b1, 60, "nominal_ready");
    repeat (5) run_edge(1'b1, 1'b1);
    repeat (2) run_edge(1'b0, 1'b0);

    // Glitch during qualification, then loss while ready and recovery
    wait_phase(PH_REL, 1'b1, 1'b0, 40, "glitch_release");
    repeat (3) run_edge(1'b1, 1'b0);
    run_edge(1'b1, 1'b1);
    run_edge(1'b1, 1'b1);
    run_edge(1'b1, 1'b0);
    wait_phase(PH_RDY, 1'b1, 1'b1, 60, "glitch_ready");
    repeat (4) run_edge(1'b1, 1'b1);
    wait_phase(PH_LOW, 1'b1, 1'b0, 10, "loss_retry");
    wait_phase(PH_REL, 1'b1, 1'b0, 40, "loss_release");
    repeat ($urandom_range(0, 20)) run_edge(1'b1, 1'b0);
    wait_phase(PH_RDY, 1'b1, 1'b1, 60, "loss_ready");
    repeat (3) run_edge(1'b1, 1'b1);
    repeat (2) run_edge(1'b0, 1'b0);

    // Timeouts to fault, then abort while in fault
    wait_phase(PH_FLT, 1'b1, 1'b0, 300, "timeout_fault");
    repeat (6) run_edge(1'b1, 1'b0);
    run_edge(1'b0, 1'b0);
    run_edge(1'b0, 1'b0);

    // Abort mid-hold, then a full hold after re-enable
    repeat (1 + $urandom_range(2, 7)) run_edge(1'b1, 1'b0);
    run_edge(1'b0, 1'b0);
    wait_phase(PH_REL, 1'b1, 1'b0, 40, "abort_rehold");
    repeat (3) run_edge(1'b1, 1'b0);
    run_edge(1'b0, 1'b0);

    // Randomized calibration waveforms with occasional enable drops
    for (int k = 0; k < 6; k++) begin
      int unsigned left;
      logic        lvl;
      left = 0;
      lvl  = 1'b0;
      for (int t = 0; t < 160; t++) begin
        if (left == 0) begin
          lvl  = ($urandom_range(0, 2) != 0);
          left = $urandom_range(1, 14);
        end
        left--;
        run_edge(($urandom_range(0, 199) != 0), lvl);
      end
      run_edge(1'b0, 1'b0);
    end
    run_edge(1'b0, 1'b0);

    // Asynchronous reset while ready
    wait_phase(PH_REL, 1'b1, 1'b0, 40, "areset_release");
    wait_phase(PH_RDY, 1'b1, 1'b1, 60, "areset_ready");
    repeat (2) run_edge(1'b1, 1'b1);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    check("areset_pre_ready", 32'(rdy), 32'd1);
`ifdef CALIB_MONITOR_LATENCY_EN
    check("latency_value", 32'(lat), 32'(m_lat));
`endif
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_ready", 32'(rdy), 32'd0);
    check("areset_mig", 32'(mig_rst), 32'd0);
    check("areset_state", 32'(st), 32'd0);
    check("areset_retry", 32'(rcnt), 32'd0);
`ifdef CALIB_MONITOR_LATENCY_EN
    check("areset_latency", 32'(lat), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
